// File: rtl/mmc3_scanline_irq_if.sv
// Signal bundle between the cartridge register decoder / PPU side and the
// MMC3 scanline IRQ unit.
interface mmc3_scanline_irq_if #(
  parameter int CNT_W = 8
);
  logic             ppu_a12;
  logic [CNT_W-1:0] latch_value;
  logic             reload_stb;
  logic             irq_disable_stb;
  logic             irq_enable_stb;
  logic             irq;
  logic [CNT_W-1:0] counter;

  modport master (
    output ppu_a12,
    output latch_value,
    output reload_stb,
    output irq_disable_stb,
    output irq_enable_stb,
    input  irq,
    input  counter
  );

  modport slave (
    input  ppu_a12,
    input  latch_value,
    input  reload_stb,
    input  irq_disable_stb,
    input  irq_enable_stb,
    output irq,
    output counter
  );
endinterface

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ unit clocked from CPU M2: filters PPU A12 rising
// edges into scanline clocks, runs the reload/decrement counter, drives irq.
module mmc3_scanline_irq #(
  parameter int A12_LOW_CYCLES = 3,
  parameter int CNT_W          = 8
) (
  input  logic               m2,
  input  logic               rst_n,
  mmc3_scanline_irq_if.slave bus
);

  localparam int              LOW_W   = $clog2(A12_LOW_CYCLES + 1);
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(A12_LOW_CYCLES);

  logic             a12_meta_r;
  logic             a12_sync_r;
  logic             a12_prev_r;
  logic [LOW_W-1:0] low_cnt_r;
  logic [CNT_W-1:0] counter_r;
  logic             reload_pending_r;
  logic             enabled_r;
  logic             irq_r;

  logic [LOW_W-1:0] low_cnt_next_s;
  logic [CNT_W-1:0] counter_next_s;
  logic             reload_pending_next_s;
  logic             enabled_next_s;
  logic             irq_next_s;
  logic             clk_evt_s;
  logic             pend_eff_s;

  // Two-flop synchroniser for the asynchronous A12 plus the edge-detect history.
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      a12_meta_r <= 1'b0;
      a12_sync_r <= 1'b0;
      a12_prev_r <= 1'b0;
    end else begin
      a12_meta_r <= bus.ppu_a12;
      a12_sync_r <= a12_meta_r;
      a12_prev_r <= a12_sync_r;
    end
  end

  // Saturating count of consecutive synchronised-low samples.
  always_comb begin
    low_cnt_next_s = low_cnt_r;
    if (a12_sync_r) begin
      low_cnt_next_s = {LOW_W{1'b0}};
    end else if (low_cnt_r != LOW_MAX) begin
      low_cnt_next_s = low_cnt_r + LOW_W'(1);
    end else begin
      low_cnt_next_s = low_cnt_r;
    end
  end

  // A rise only counts when the low run before it was long enough (pre-edge count).
  assign clk_evt_s  = a12_sync_r & ~a12_prev_r & (low_cnt_r == LOW_MAX);
  assign pend_eff_s = reload_pending_r | bus.reload_stb;

  // Counter, reload flag, enable and IRQ next-state; disable outranks everything.
  always_comb begin
    counter_next_s        = counter_r;
    reload_pending_next_s = pend_eff_s;
    enabled_next_s        = enabled_r;
    irq_next_s            = irq_r;

    if (clk_evt_s) begin
      if ((counter_r == {CNT_W{1'b0}}) || pend_eff_s) begin
        counter_next_s        = bus.latch_value;
        reload_pending_next_s = 1'b0;
      end else begin
        counter_next_s = counter_r - CNT_W'(1);
      end
    end else begin
      counter_next_s = counter_r;
    end

    if (bus.irq_disable_stb) begin
      enabled_next_s = 1'b0;
    end else if (bus.irq_enable_stb) begin
      enabled_next_s = 1'b1;
    end else begin
      enabled_next_s = enabled_r;
    end

    if (bus.irq_disable_stb) begin
      irq_next_s = 1'b0;
    end else if (clk_evt_s && (counter_next_s == {CNT_W{1'b0}}) && enabled_next_s) begin
      irq_next_s = 1'b1;
    end else begin
      irq_next_s = irq_r;
    end
  end

  // State registers; outputs come straight from flops.
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_r        <= {LOW_W{1'b0}};
      counter_r        <= {CNT_W{1'b0}};
      reload_pending_r <= 1'b0;
      enabled_r        <= 1'b0;
      irq_r            <= 1'b0;
    end else begin
      low_cnt_r        <= low_cnt_next_s;
      counter_r        <= counter_next_s;
      reload_pending_r <= reload_pending_next_s;
      enabled_r        <= enabled_next_s;
      irq_r            <= irq_next_s;
    end
  end

  assign bus.irq     = irq_r;
  assign bus.counter = counter_r;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed self-checking bench for mmc3_scanline_irq; inputs change and
// outputs are checked on the falling edge of m2.
module tb_mmc3_scanline_irq;

  logic m2;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mmc3_scanline_irq_if #(.CNT_W(8)) bus ();

  mmc3_scanline_irq #(.A12_LOW_CYCLES(3), .CNT_W(8)) dut (
    .m2    (m2),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic cycle(input int n);
    repeat (n) @(negedge m2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // High for 2 m2, then low for low_after m2; the counter moves 1 cycle into the low part.
  task automatic pulse(input int low_after);
    bus.ppu_a12 = 1'b1;
    cycle(2);
    bus.ppu_a12 = 1'b0;
    cycle(low_after);
  endtask

  task automatic strobe_reload();
    bus.reload_stb = 1'b1;
    cycle(1);
    bus.reload_stb = 1'b0;
  endtask

  task automatic strobe_enable();
    bus.irq_enable_stb = 1'b1;
    cycle(1);
    bus.irq_enable_stb = 1'b0;
  endtask

  task automatic strobe_disable();
    bus.irq_disable_stb = 1'b1;
    cycle(1);
    bus.irq_disable_stb = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n               = 1'b0;
    bus.ppu_a12         = 1'b0;
    bus.latch_value     = 8'd5;
    bus.reload_stb      = 1'b0;
    bus.irq_disable_stb = 1'b0;
    bus.irq_enable_stb  = 1'b0;

    cycle(2);
    chk("reset_counter", bus.counter, 32'd0);
    chk("reset_irq", bus.irq, 32'd0);
    rst_n = 1'b1;
    cycle(1);
    strobe_enable();
    cycle(4);

    // Six filtered pulses from counter 0 with latch 5: 5,4,3,2,1,0, irq on the last.
    for (int i = 0; i < 6; i++) begin
      bus.ppu_a12 = 1'b1;
      cycle(2);
      chk("t1_pre_counter", bus.counter, (i == 0) ? 32'd0 : 32'(6 - i));
      chk("t1_pre_irq", bus.irq, 32'd0);
      bus.ppu_a12 = 1'b0;
      cycle(1);
      chk("t1_counter", bus.counter, 32'(5 - i));
      chk("t1_irq", bus.irq, (i == 5) ? 32'd1 : 32'd0);
      cycle(3);
    end

    strobe_disable();
    chk("t2_disable_irq", bus.irq, 32'd0);
    pulse(4);
    chk("t2_reload5", bus.counter, 32'd5);
    // Second rise follows only 2 low cycles and must be ignored.
    bus.ppu_a12 = 1'b1; cycle(2);
    bus.ppu_a12 = 1'b0; cycle(2);
    bus.ppu_a12 = 1'b1; cycle(2);
    bus.ppu_a12 = 1'b0; cycle(4);
    chk("t2_short_low", bus.counter, 32'd4);
    // Exactly 3 low cycles: both rises count.
    bus.ppu_a12 = 1'b1; cycle(2);
    bus.ppu_a12 = 1'b0; cycle(3);
    bus.ppu_a12 = 1'b1; cycle(2);
    bus.ppu_a12 = 1'b0; cycle(4);
    chk("t2_low3", bus.counter, 32'd2);
    chk("t2_irq_disabled", bus.irq, 32'd0);

    bus.latch_value = 8'd0;
    strobe_enable();
    chk("t3_enable_no_irq", bus.irq, 32'd0);
    strobe_reload();
    chk("t3_reload_no_evt", bus.counter, 32'd2);
    pulse(4);
    chk("t3_l0_counter", bus.counter, 32'd0);
    chk("t3_l0_irq", bus.irq, 32'd1);
    strobe_disable();
    chk("t3_ack", bus.irq, 32'd0);
    pulse(4);
    chk("t3_disabled_counter", bus.counter, 32'd0);
    chk("t3_disabled_irq", bus.irq, 32'd0);
    strobe_enable();
    chk("t3_rearm_no_irq", bus.irq, 32'd0);
    pulse(4);
    chk("t3_rearm_irq", bus.irq, 32'd1);

    bus.latch_value = 8'd4;
    strobe_reload();
    pulse(4);
    pulse(4);
    chk("t4_counter3", bus.counter, 32'd3);
    bus.latch_value = 8'd10;
    bus.ppu_a12 = 1'b1;
    cycle(2);
    bus.reload_stb = 1'b1;
    bus.ppu_a12 = 1'b0;
    cycle(1);
    bus.reload_stb = 1'b0;
    chk("t4_same_cycle_reload", bus.counter, 32'd10);
    chk("t4_irq_held", bus.irq, 32'd1);
    cycle(3);
    pulse(4);
    chk("t4_pending_cleared", bus.counter, 32'd9);

    bus.irq_disable_stb = 1'b1;
    bus.irq_enable_stb  = 1'b1;
    cycle(1);
    bus.irq_disable_stb = 1'b0;
    bus.irq_enable_stb  = 1'b0;
    chk("t5_both_irq", bus.irq, 32'd0);
    bus.latch_value = 8'd0;
    strobe_reload();
    pulse(4);
    chk("t5_zero_counter", bus.counter, 32'd0);
    chk("t5_stays_disabled", bus.irq, 32'd0);
    // Enable coinciding with a scanline clock that lands on 0 raises irq.
    bus.ppu_a12 = 1'b1;
    cycle(2);
    bus.irq_enable_stb = 1'b1;
    bus.ppu_a12 = 1'b0;
    cycle(1);
    bus.irq_enable_stb = 1'b0;
    chk("t5_en_evt_irq", bus.irq, 32'd1);
    cycle(3);
    // Disable coinciding with a scanline clock: counter updates, irq cleared.
    bus.latch_value = 8'd3;
    bus.ppu_a12 = 1'b1;
    cycle(2);
    bus.irq_disable_stb = 1'b1;
    bus.ppu_a12 = 1'b0;
    cycle(1);
    bus.irq_disable_stb = 1'b0;
    chk("t5_dis_evt_counter", bus.counter, 32'd3);
    chk("t5_dis_evt_irq", bus.irq, 32'd0);
    cycle(3);

    strobe_enable();
    bus.latch_value = 8'd0;
    strobe_reload();
    pulse(4);
    chk("t6_setup_irq0", bus.irq, 32'd1);
    bus.latch_value = 8'd7;
    pulse(4);
    chk("t6_setup_counter", bus.counter, 32'd7);
    chk("t6_setup_irq", bus.irq, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_counter", bus.counter, 32'd0);
    chk("t6_async_irq", bus.irq, 32'd0);
    bus.ppu_a12 = 1'b1;
    cycle(2);
    rst_n = 1'b1;
    cycle(4);
    chk("t6_release_rise", bus.counter, 32'd0);
    bus.ppu_a12 = 1'b0; cycle(2);
    bus.ppu_a12 = 1'b1; cycle(2);
    bus.ppu_a12 = 1'b0; cycle(1);
    chk("t6_short_after_rst", bus.counter, 32'd0);
    cycle(4);
    bus.ppu_a12 = 1'b1; cycle(2);
    bus.ppu_a12 = 1'b0; cycle(1);
    chk("t6_full_low", bus.counter, 32'd7);
    chk("t6_irq_after_rst", bus.irq, 32'd0);
    cycle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmc3_scanline_irq.md
Name: mmc3_scanline_irq

Overview:
- Clocked MMC3-style scanline IRQ unit, run from the CPU M2 clock.
- Sits directly downstream of the cartridge register decoder. It consumes the decoded $C000/$C001/$E000/$E001 write strobes, the IRQ latch value and PPU A12.
- Filters A12 rising edges into scanline clocks, runs the reload/decrement counter and drives the cartridge IRQ request.
- Replaces the unclocked A12-edge counter with a single-clock, reset-safe implementation.

Parameters:
- A12_LOW_CYCLES, 3: consecutive M2 cycles A12 must be sampled low before a rising edge counts as a scanline clock.
- CNT_W, 8: counter and latch width.

Ports:
- m2  input  1  CPU M2 clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ppu_a12  input  1  PPU address bit 12, asynchronous to m2.
- latch_value  input  CNT_W  IRQ reload value ($C000 register), held stable by the decoder.
- reload_stb  input  1  one-m2-cycle pulse on a $C001 write.
- irq_disable_stb  input  1  one-m2-cycle pulse on a $E000 write; also acknowledges the IRQ.
- irq_enable_stb  input  1  one-m2-cycle pulse on a $E001 write.
- irq  output  1  active-high IRQ request; the top level converts it to open-drain (0 when set, Z otherwise).
- counter  output  CNT_W  current counter value, for debug/verification.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - sync flops = 0, a12_prev = 0, low_cnt = 0, counter = 0, reload_pending = 0, enabled = 0, irq = 0.
  - Reset mid-operation aborts everything. The first scanline clock after release needs a full A12_LOW_CYCLES low period.
- Synchroniser: ppu_a12 passes through 2 flops to give a12_s; a12_prev holds the previous a12_s.
- Low filter (low_cnt, saturating at A12_LOW_CYCLES):
  - a12_s=0: low_cnt increments, stopping at A12_LOW_CYCLES.
  - a12_s=1: low_cnt = 0.
- Scanline clock (clk_evt): a12_s=1 AND a12_prev=0 AND low_cnt==A12_LOW_CYCLES, with low_cnt taken as its pre-edge value. Shorter low pulses are ignored silently.
- reload_stb sets reload_pending. An effective pending value, pend_eff = reload_pending OR reload_stb, is used in the same cycle.
- On clk_evt:
  - If counter==0 OR pend_eff: counter = latch_value and reload_pending is cleared.
  - Otherwise: counter = counter-1.
  - If the new counter value is 0 AND enabled_next=1: irq = 1.
  - latch_value=0 therefore raises irq on every scanline clock while enabled.
- Without clk_evt, reload_stb only sets reload_pending; the counter does not change.
- enabled_next:
  - irq_disable_stb: 0, and irq is cleared.
  - else irq_enable_stb: 1.
  - else the held value.
- Priority: disable beats enable when both arrive in the same cycle. Disable beats a same-cycle clk_evt, so irq stays 0 even though the counter still updates.
- Enable does not set irq by itself. If enable and clk_evt coincide and the new counter is 0, irq = 1.
- irq holds until irq_disable_stb or reset. Further clock events never clear it.
- Latency:
  - An A12 rise that meets setup before m2 edge k updates counter and irq at edge k+2 (2 sync stages + edge detect).
  - Strobes take effect at the edge on which they are sampled high.
- Counter decrement never underflows, because 0 always reloads.
- Width rule: every counter operation is modulo 2^CNT_W, with no carry out.

Test Plan:
- Reset with latch_value=5, enable, then 6 filtered A12 pulses (low ≥4 m2, high 2 m2) -> counter 5,4,3,2,1,0. irq rises at the edge where counter becomes 0, exactly 2 edges after the 6th A12 rise.
- A12 low for only 2 m2 between pulses -> no counter change. A low run of exactly 3 -> the next rise counts.
- latch_value=0, enabled, 3 valid pulses -> counter stays 0 and irq is set after the 1st pulse. irq_disable_stb clears it; irq_enable_stb then re-arms, and the next pulse sets irq again.
- Counter=3, reload_stb pulsed in the same cycle as clk_evt with latch_value=10 -> counter=10, reload_pending=0. Next pulse -> 9.
- irq_disable_stb and irq_enable_stb asserted together while irq=1 -> irq=0 and enabled=0. A later pulse driving the counter to 0 leaves irq at 0.
- rst_n asserted asynchronously mid-low-run with counter=7 and irq=1 -> all outputs 0 immediately. After release, a rise after only 2 low cycles does not count.
